// File: rtl/pipeline_mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface pipeline_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/pipeline_mem_stage.sv
// MEM stage of the RV64 pipeline: issues registered req/ack data-bus accesses,
// extracts/extends load lanes, builds store lanes/strobes, stalls the front of
// the pipe while an access is outstanding and fills the MEM->WB registers.
module pipeline_mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [63:0]                 pc_EX,
  input  logic [63:0]                 alu_result_EX,
  input  logic [63:0]                 reg_data2_EX,
  input  logic [4:0]                  rd_EX,
  input  logic                        rf_wr_en_EX,
  input  logic [1:0]                  rf_wr_sel_EX,
  input  logic [2:0]                  dm_rd_ctrl_EX,
  input  logic [2:0]                  dm_wr_ctrl_EX,
  pipeline_mem_stage_if.master        dbus,
  output logic                        mem_stall,
  output logic [63:0]                 pc_MEM,
  output logic [63:0]                 alu_result_MEM,
  output logic [63:0]                 mem_rdata_MEM,
  output logic [4:0]                  rd_MEM,
  output logic                        rf_wr_en_MEM,
  output logic [1:0]                  rf_wr_sel_MEM,
  output logic [1:0]                  exc_MEM
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      rbuf_q;
  logic             misalign_q;
  logic             timeout_q;

  logic [2:0]       off;
  logic             is_store;
  logic             is_load;
  logic             mem_op;
  logic             misaligned;
  logic             timeout_hit;
  logic [7:0]       strb_base;
  logic [63:0]      shifted;
  logic [63:0]      load_data;
  logic [1:0]       exc_now;

  assign off         = alu_result_EX[2:0];
  assign is_store    = (dm_wr_ctrl_EX != 3'd0) && (dm_wr_ctrl_EX <= 3'd4);
  assign is_load     = (dm_rd_ctrl_EX != 3'd0) && !is_store;
  assign mem_op      = is_store || is_load;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_stall   = mem_op && (state_q != RESP);
  assign exc_now     = (state_q == RESP) ? {timeout_q, misalign_q} : 2'b00;

  // Access-size decode: base byte strobe for stores and alignment check.
  always_comb begin
    misaligned = 1'b0;
    strb_base  = 8'h00;
    if (is_store) begin
      case (dm_wr_ctrl_EX)
        3'd1:    strb_base = 8'h01;
        3'd2:    begin strb_base = 8'h03; misaligned = off[0];    end
        3'd3:    begin strb_base = 8'h0F; misaligned = |off[1:0]; end
        default: begin strb_base = 8'hFF; misaligned = |off;      end
      endcase
    end else if (is_load) begin
      case (dm_rd_ctrl_EX)
        3'd3, 3'd4: misaligned = off[0];
        3'd5, 3'd6: misaligned = |off[1:0];
        3'd7:       misaligned = |off;
        default:    misaligned = 1'b0;
      endcase
    end
  end

  // Load lane extraction from the buffered doubleword with sign/zero extension.
  always_comb begin
    shifted   = rbuf_q >> {off, 3'b000};
    load_data = 64'd0;
    if (is_load) begin
      case (dm_rd_ctrl_EX)
        3'd1:    load_data = {{56{shifted[7]}}, shifted[7:0]};
        3'd2:    load_data = {56'd0, shifted[7:0]};
        3'd3:    load_data = {{48{shifted[15]}}, shifted[15:0]};
        3'd4:    load_data = {48'd0, shifted[15:0]};
        3'd5:    load_data = {{32{shifted[31]}}, shifted[31:0]};
        3'd6:    load_data = {32'd0, shifted[31:0]};
        default: load_data = shifted;
      endcase
    end
  end

  // Access FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Access FSM next state: misaligned ops skip the bus, RESP waits for the freeze to lift.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = misaligned ? RESP : REQ;
      REQ:     if (dbus.dmem_ack || timeout_hit) state_d = RESP;
      RESP:    if (!stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus request registers, timeout counter, read buffer and exception flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbus.dmem_req   <= 1'b0;
      dbus.dmem_we    <= 1'b0;
      dbus.dmem_addr  <= 64'd0;
      dbus.dmem_wdata <= 64'd0;
      dbus.dmem_wstrb <= 8'd0;
      cnt_q           <= '0;
      rbuf_q          <= 64'd0;
      misalign_q      <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            misalign_q <= misaligned;
            timeout_q  <= 1'b0;
            if (misaligned) begin
              rbuf_q <= 64'd0;
            end else begin
              dbus.dmem_req   <= 1'b1;
              dbus.dmem_we    <= is_store;
              dbus.dmem_addr  <= {alu_result_EX[63:3], 3'b000};
              dbus.dmem_wdata <= is_store ? (reg_data2_EX << {off, 3'b000}) : 64'd0;
              dbus.dmem_wstrb <= is_store ? (strb_base << off) : 8'd0;
              cnt_q           <= '0;
            end
          end
        end
        REQ: begin
          if (dbus.dmem_ack) begin
            dbus.dmem_req <= 1'b0;
            rbuf_q        <= dbus.dmem_rdata;
          end else if (timeout_hit) begin
            dbus.dmem_req <= 1'b0;
            rbuf_q        <= 64'd0;
            timeout_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // MEM->WB registers: load when flowing, insert a bubble while stalling, hold when frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_MEM         <= 64'd0;
      alu_result_MEM <= 64'd0;
      mem_rdata_MEM  <= 64'd0;
      rd_MEM         <= 5'd0;
      rf_wr_en_MEM   <= 1'b0;
      rf_wr_sel_MEM  <= 2'd0;
      exc_MEM        <= 2'd0;
    end else if (!stall) begin
      if (!mem_stall) begin
        pc_MEM         <= pc_EX;
        alu_result_MEM <= alu_result_EX;
        mem_rdata_MEM  <= load_data;
        rd_MEM         <= rd_EX;
        rf_wr_sel_MEM  <= rf_wr_sel_EX;
        exc_MEM        <= exc_now;
        rf_wr_en_MEM   <= rf_wr_en_EX && (exc_now == 2'b00);
      end else begin
        rf_wr_en_MEM <= 1'b0;
        exc_MEM      <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Scoreboard bench for pipeline_mem_stage: stimulus pushes hand-computed
// MEM->WB results, a monitor pops and compares whenever the stage loads.
module tb_pipeline_mem_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [63:0] pc_EX;
  logic [63:0] alu_result_EX;
  logic [63:0] reg_data2_EX;
  logic [4:0]  rd_EX;
  logic        rf_wr_en_EX;
  logic [1:0]  rf_wr_sel_EX;
  logic [2:0]  dm_rd_ctrl_EX;
  logic [2:0]  dm_wr_ctrl_EX;
  logic        mem_stall;
  logic [63:0] pc_MEM;
  logic [63:0] alu_result_MEM;
  logic [63:0] mem_rdata_MEM;
  logic [4:0]  rd_MEM;
  logic        rf_wr_en_MEM;
  logic [1:0]  rf_wr_sel_MEM;
  logic [1:0]  exc_MEM;

  pipeline_mem_stage_if dbus();

  pipeline_mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .pc_EX          (pc_EX),
    .alu_result_EX  (alu_result_EX),
    .reg_data2_EX   (reg_data2_EX),
    .rd_EX          (rd_EX),
    .rf_wr_en_EX    (rf_wr_en_EX),
    .rf_wr_sel_EX   (rf_wr_sel_EX),
    .dm_rd_ctrl_EX  (dm_rd_ctrl_EX),
    .dm_wr_ctrl_EX  (dm_wr_ctrl_EX),
    .dbus           (dbus.master),
    .mem_stall      (mem_stall),
    .pc_MEM         (pc_MEM),
    .alu_result_MEM (alu_result_MEM),
    .mem_rdata_MEM  (mem_rdata_MEM),
    .rd_MEM         (rd_MEM),
    .rf_wr_en_MEM   (rf_wr_en_MEM),
    .rf_wr_sel_MEM  (rf_wr_sel_MEM),
    .exc_MEM        (exc_MEM)
  );

  typedef struct {
    logic [63:0] pc;
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  sel;
    logic [1:0]  exc;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] data2,
                               input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                               input logic [2:0] rdc, input logic [2:0] wrc, input bit push,
                               input logic [63:0] expRdata, input logic [1:0] expExc);
    exp_t e;
    pc_EX         = pc;
    alu_result_EX = alu;
    reg_data2_EX  = data2;
    rd_EX         = rd;
    rf_wr_en_EX   = wen;
    rf_wr_sel_EX  = sel;
    dm_rd_ctrl_EX = rdc;
    dm_wr_ctrl_EX = wrc;
    if (push) begin
      e.pc    = pc;
      e.alu   = alu;
      e.rdata = expRdata;
      e.rd    = rd;
      e.wen   = wen && (expExc == 2'b00);
      e.sel   = sel;
      e.exc   = expExc;
      expQ.push_back(e);
    end
  endtask

  // Drives the memory side of one access and records what the stage did on the bus.
  task automatic doAccess(input int ackDelay, input logic [63:0] rdata,
                          output int stallCycles, output int reqCycles,
                          output logic [63:0] busAddr, output logic [63:0] busWdata,
                          output logic [7:0] busStrb, output logic busWe,
                          output bit busStable, output bit bubbleOk);
    int waitCnt;
    bit acked;
    bit done;
    stallCycles = 0; reqCycles = 0; waitCnt = 0; acked = 0; done = 0;
    busStable = 1; bubbleOk = 1;
    busAddr = '0; busWdata = '0; busStrb = '0; busWe = 1'b0;
    #1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (!mem_stall) begin
        done = 1;
      end else begin
        stallCycles++;
        if (stallCycles >= 2 && (rf_wr_en_MEM !== 1'b0 || exc_MEM !== 2'b00)) bubbleOk = 0;
        if (dbus.dmem_req) begin
          if (reqCycles == 0) begin
            busAddr = dbus.dmem_addr; busWdata = dbus.dmem_wdata;
            busStrb = dbus.dmem_wstrb; busWe = dbus.dmem_we;
          end else if (busAddr !== dbus.dmem_addr || busWdata !== dbus.dmem_wdata ||
                       busStrb !== dbus.dmem_wstrb || busWe !== dbus.dmem_we) begin
            busStable = 0;
          end
          reqCycles++;
          if (!acked && ackDelay >= 0 && waitCnt == ackDelay) begin
            dbus.dmem_ack   = 1'b1;
            dbus.dmem_rdata = rdata;
            acked = 1;
          end
          waitCnt++;
        end
        @(negedge clk);
        dbus.dmem_ack   = 1'b0;
        dbus.dmem_rdata = JUNK;
        #1;
      end
    end
    checkOutput("access_done", 64'(done), 64'd1);
  endtask

  // Scoreboard monitor: whenever the stage loads its MEM->WB registers, compare with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    bit   loadNow;
    loadNow = !reset && !stall && !mem_stall;
    if (loadNow) begin
      #1;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL mem_regs_unexpected_load actual pc_MEM=0x%h expected no load", pc_MEM);
      end else begin
        e = expQ.pop_front();
        checkOutput("mem_pc",       pc_MEM,                e.pc);
        checkOutput("mem_alu",      alu_result_MEM,        e.alu);
        checkOutput("mem_rdata",    mem_rdata_MEM,         e.rdata);
        checkOutput("mem_rd",       64'(rd_MEM),           64'(e.rd));
        checkOutput("mem_wen",      64'(rf_wr_en_MEM),     64'(e.wen));
        checkOutput("mem_sel",      64'(rf_wr_sel_MEM),    64'(e.sel));
        checkOutput("mem_exc",      64'(exc_MEM),          64'(e.exc));
      end
    end
  end

  // Directed test sequence.
  initial begin
    int          sc, rc;
    logic [63:0] ba, bw;
    logic [7:0]  bs;
    logic        bwe;
    bit          st, bo, seen;

    reset = 1'b1;
    stall = 1'b0;
    dbus.dmem_ack   = 1'b0;
    dbus.dmem_rdata = JUNK;
    applyStimulus(64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 2'd0, 3'd0, 3'd0, 0, 64'd0, 2'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_req",      64'(dbus.dmem_req), 64'd0);
    checkOutput("reset_pc_mem",   pc_MEM,             64'd0);
    checkOutput("reset_wen_mem",  64'(rf_wr_en_MEM),  64'd0);
    checkOutput("reset_mem_stall",64'(mem_stall),     64'd0);

    // ALU op flows through in one cycle without stalling.
    reset = 1'b0;
    applyStimulus(64'h100, 64'h1234, 64'd0, 5'd5, 1'b1, 2'd1, 3'd0, 3'd0, 1, 64'd0, 2'd0);
    #1;
    checkOutput("alu_mem_stall", 64'(mem_stall), 64'd0);

    // LB @0x1003, ack in second REQ cycle.
    @(negedge clk);
    applyStimulus(64'h104, 64'h1003, 64'd0, 5'd6, 1'b1, 2'd2, 3'd1, 3'd0, 1, 64'hFFFF_FFFF_FFFF_FF80, 2'd0);
    doAccess(1, 64'h0000_0000_8000_0000, sc, rc, ba, bw, bs, bwe, st, bo);
    checkOutput("lb_stall_cycles", 64'(sc), 64'd3);
    checkOutput("lb_addr",  ba, 64'h1000);
    checkOutput("lb_we",    64'(bwe), 64'd0);
    checkOutput("lb_wstrb", 64'(bs), 64'd0);
    checkOutput("lb_bus_stable", 64'(st), 64'd1);
    checkOutput("lb_bubble", 64'(bo), 64'd1);

    // SH @0x2006.
    @(negedge clk);
    applyStimulus(64'h108, 64'h2006, 64'hABCD, 5'd0, 1'b0, 2'd0, 3'd0, 3'd2, 1, 64'd0, 2'd0);
    doAccess(0, 64'd0, sc, rc, ba, bw, bs, bwe, st, bo);
    checkOutput("sh_addr",  ba, 64'h2000);
    checkOutput("sh_we",    64'(bwe), 64'd1);
    checkOutput("sh_wstrb", 64'(bs), 64'hC0);
    checkOutput("sh_wdata", bw, 64'hABCD_0000_0000_0000);
    checkOutput("sh_stall_cycles", 64'(sc), 64'd2);

    // Misaligned LW @0x3002: no bus request, misalign exception.
    @(negedge clk);
    applyStimulus(64'h10C, 64'h3002, 64'd0, 5'd7, 1'b1, 2'd2, 3'd5, 3'd0, 1, 64'd0, 2'b01);
    doAccess(0, 64'd0, sc, rc, ba, bw, bs, bwe, st, bo);
    checkOutput("lw_mis_req_cycles", 64'(rc), 64'd0);
    checkOutput("lw_mis_stall_cycles", 64'(sc), 64'd1);

    // LD with no ack: bus timeout after 16 REQ cycles.
    @(negedge clk);
    applyStimulus(64'h110, 64'h4000, 64'd0, 5'd8, 1'b1, 2'd2, 3'd7, 3'd0, 1, 64'd0, 2'b10);
    doAccess(-1, 64'd0, sc, rc, ba, bw, bs, bwe, st, bo);
    checkOutput("ld_to_req_cycles", 64'(rc), 64'd16);
    checkOutput("ld_to_bubble", 64'(bo), 64'd1);
    checkOutput("ld_to_bus_stable", 64'(st), 64'd1);

    // LHU @0x5006 zero-extends the top halfword.
    @(negedge clk);
    applyStimulus(64'h114, 64'h5006, 64'd0, 5'd9, 1'b1, 2'd2, 3'd4, 3'd0, 1, 64'h0000_0000_0000_8001, 2'd0);
    doAccess(0, 64'h8001_0000_0000_0000, sc, rc, ba, bw, bs, bwe, st, bo);
    checkOutput("lhu_addr", ba, 64'h5000);

    // LW @0x6004 sign-extends the upper word.
    @(negedge clk);
    applyStimulus(64'h118, 64'h6004, 64'd0, 5'd10, 1'b1, 2'd2, 3'd5, 3'd0, 1, 64'hFFFF_FFFF_F000_0001, 2'd0);
    doAccess(2, 64'hF000_0001_1234_5678, sc, rc, ba, bw, bs, bwe, st, bo);
    checkOutput("lw_req_cycles", 64'(rc), 64'd3);

    // Load and store both set: store wins, rf_wr_en passes through.
    @(negedge clk);
    applyStimulus(64'h11C, 64'h7000, 64'h1122_3344_5566_7788, 5'd11, 1'b1, 2'd0, 3'd7, 3'd4, 1, 64'd0, 2'd0);
    doAccess(0, 64'hFFFF_FFFF_FFFF_FFFF, sc, rc, ba, bw, bs, bwe, st, bo);
    checkOutput("sd_we",    64'(bwe), 64'd1);
    checkOutput("sd_wstrb", 64'(bs), 64'hFF);
    checkOutput("sd_wdata", bw, 64'h1122_3344_5566_7788);

    // wr_ctrl=5 is not a memory op.
    @(negedge clk);
    applyStimulus(64'h120, 64'h55AA, 64'h99, 5'd12, 1'b1, 2'd1, 3'd0, 3'd5, 1, 64'd0, 2'd0);
    #1;
    checkOutput("wr5_mem_stall", 64'(mem_stall), 64'd0);

    // LBU @0x8001, then freeze in RESP for three cycles.
    @(negedge clk);
    applyStimulus(64'h124, 64'h8001, 64'd0, 5'd13, 1'b1, 2'd2, 3'd2, 3'd0, 1, 64'h0000_0000_0000_00AB, 2'd0);
    doAccess(0, 64'h0000_0000_0000_AB00, sc, rc, ba, bw, bs, bwe, st, bo);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("resp_hold_mem_stall", 64'(mem_stall), 64'd0);
      checkOutput("resp_hold_req", 64'(dbus.dmem_req), 64'd0);
      checkOutput("resp_hold_pc", pc_MEM, 64'h120);
    end
    stall = 1'b0;

    // Reset while in REQ, then a late ack must be ignored.
    @(negedge clk);
    applyStimulus(64'h128, 64'h9000, 64'd0, 5'd14, 1'b1, 2'd2, 3'd7, 3'd0, 0, 64'd0, 2'd0);
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (dbus.dmem_req) seen = 1;
    end
    checkOutput("rst_req_seen", 64'(seen), 64'd1);
    reset = 1'b1;
    applyStimulus(64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 2'd0, 3'd0, 3'd0, 0, 64'd0, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_req",       64'(dbus.dmem_req), 64'd0);
    checkOutput("rst_mem_stall", 64'(mem_stall), 64'd0);
    checkOutput("rst_alu_mem",   alu_result_MEM, 64'd0);
    applyStimulus(64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 2'd0, 3'd0, 3'd0, 1, 64'd0, 2'd0);
    dbus.dmem_ack   = 1'b1;
    dbus.dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    dbus.dmem_ack   = 1'b0;
    dbus.dmem_rdata = JUNK;
    stall = 1'b1;
    #1;
    checkOutput("late_ack_req", 64'(dbus.dmem_req), 64'd0);
    checkOutput("late_ack_rdata", mem_rdata_MEM, 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
